seq_pattern_tx: RTL and testbench



---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_pattern_tx_piso.sv | 28 ++
 rtl/seq_pattern_tx.sv | 120 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter and its detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 5;
  localparam logic [4:0]  DEFAULT_PAT   = 5'b10101;

endpackage

// File: rtl/seq_pattern_tx_piso.sv
// Parallel-in/serial-out shift register: load has priority over shift, MSB is the serial output.
module seq_piso #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Zero fill on shift so the line idles low once a pass has drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out MSB-first.
// Back-to-back repeats are compiled in only when SEQ_TX_REPEAT_EN is defined.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         pattern,
  input  logic [CNT_W-1:0]         repeat_n,
  output logic                     x,
  output logic                     valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_t           state, state_d;
  logic [IDX_W-1:0] bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] sr_din;

`ifdef SEQ_TX_REPEAT_EN
  logic [CNT_W-1:0] rep_left, rep_left_d;
`else
  logic unused_repeat_n;
  assign unused_repeat_n = ^repeat_n;
`endif

  seq_piso #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (x)
  );

  // State and status registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pat_q   <= WIDTH'(DEFAULT_PAT);
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_TX_REPEAT_EN
      rep_left <= '0;
`endif
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      pat_q   <= pat_d;
      valid   <= (state_d == SEND);
      busy    <= (state_d == SEND);
      done    <= (state_d == DONE);
`ifdef SEQ_TX_REPEAT_EN
      rep_left <= rep_left_d;
`endif
    end
  end

  assign bit_idx = bit_cnt;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    pat_d     = pat_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = pattern;
`ifdef SEQ_TX_REPEAT_EN
    rep_left_d = rep_left;
`endif
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d   = SEND;
          sr_load   = 1'b1;
          pat_d     = pattern;
          bit_cnt_d = IDX_W'(WIDTH - 1);
`ifdef SEQ_TX_REPEAT_EN
          rep_left_d = repeat_n;
`endif
        end
      end
      SEND: begin
        if (bit_cnt != '0) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt - IDX_W'(1);
        end else begin
          // Final pass drains the register to zero so x idles low afterwards.
          sr_shift  = 1'b1;
          state_d   = DONE;
          bit_cnt_d = '0;
`ifdef SEQ_TX_REPEAT_EN
          if (rep_left != '0) begin
            sr_shift   = 1'b0;
            sr_load    = 1'b1;
            sr_din     = pat_q;
            state_d    = SEND;
            bit_cnt_d  = IDX_W'(WIDTH - 1);
            rep_left_d = rep_left - CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (WIDTH=5, CNT_W=4).
module tb_seq_pattern_tx;

`ifdef SEQ_TX_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] pattern;
  logic [3:0] repeat_n;
  logic       x, valid, busy, done;
  logic [2:0] bit_idx;

  int n_cmp;
  int n_err;
  logic [79:0] got_stream;

  seq_pattern_tx #(.WIDTH(5), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .x        (x),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, ".x"},       32'(x),       32'd0);
    check({tag, ".valid"},   32'(valid),   32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".done"},    32'(done),    32'(exp_done));
    check({tag, ".bit_idx"}, 32'(bit_idx), 32'd0);
  endtask

  task automatic check_bit(input string tag, input logic exp_x, input int b);
    check({tag, ".x"},       32'(x),       32'(exp_x));
    check({tag, ".valid"},   32'(valid),   32'd1);
    check({tag, ".busy"},    32'(busy),    32'd1);
    check({tag, ".done"},    32'(done),    32'd0);
    check({tag, ".bit_idx"}, 32'(bit_idx), 32'(b));
  endtask

  // Start one transmission and check every cycle through DONE and back to IDLE.
  task automatic run_stream(input string tag, input logic [4:0] pat, input logic [3:0] rep);
    int passes;
    passes     = REP_EN ? int'(rep) + 1 : 1;
    got_stream = '0;
    pattern    = pat;
    repeat_n   = rep;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int b = 4; b >= 0; b--) begin
        check_bit(tag, pat[b], b);
        got_stream = {got_stream[78:0], x};
        step();
      end
    end
    check_quiet({tag, ".done_cyc"}, 1'b1);
    step();
    check_quiet({tag, ".idle"}, 1'b0);
  endtask

  initial begin
    logic [4:0]  orig;
    logic [14:0] exp15;
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;

    step();
    step();
    check_quiet("reset", 1'b0);
    reset = 1'b0;
    step();
    check_quiet("idle_after_reset", 1'b0);

    run_stream("p10101_r0", 5'b10101, 4'd0);
    check("p10101_r0.stream", 32'(got_stream[4:0]), 32'b10101);

    run_stream("p10101_r2", 5'b10101, 4'd2);
    exp15 = REP_EN ? 15'b101011010110101 : 15'b000000000010101;
    check("p10101_r2.stream", 32'(got_stream[14:0]), 32'(exp15));

    // Start held high, pattern disturbed mid-send; re-accept in the DONE cycle.
    orig     = 5'b10101;
    pattern  = orig;
    repeat_n = 4'd0;
    start    = 1'b1;
    step();
    for (int b = 4; b >= 0; b--) begin
      if (b == 2) pattern = 5'b11111;
      check_bit("hold", orig[b], b);
      step();
    end
    check_quiet("hold.done_cyc", 1'b1);
    step();
    start = 1'b0;
    for (int b = 4; b >= 0; b--) begin
      check_bit("hold.next", 1'b1, b);
      step();
    end
    check_quiet("hold.next_done", 1'b1);
    step();
    check_quiet("hold.idle", 1'b0);

    // Reset arrives while the third bit is on the line.
    pattern = 5'b10101;
    start   = 1'b1;
    step();
    start = 1'b0;
    check_bit("rst_mid.b4", 1'b1, 4);
    step();
    check_bit("rst_mid.b3", 1'b0, 3);
    step();
    check_bit("rst_mid.b2", 1'b1, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_quiet("rst_mid.after", 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_quiet("rst_mid.no_done", 1'b0);
    end

    run_stream("p10000_r0", 5'b10000, 4'd0);
    check("p10000_r0.stream", 32'(got_stream[4:0]), 32'b10000);

    run_stream("p01101_r15", 5'b01101, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
